// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes, ALU/immediate/mux select encodings and the ImmSrc helper.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_LUI      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11
    } state_t;

    // Opcodes (Instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ImmSrc encodings
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALUOp encodings (FSM -> ALU decoder)
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMMEXT = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Immediate format is a pure function of the opcode.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_src_of = IMM_S;
            OP_BRANCH: imm_src_of = IMM_B;
            OP_JAL:    imm_src_of = IMM_J;
            OP_LUI:    imm_src_of = IMM_U;
            default:   imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp plus funct fields to ALUControl.
module riscv_alu_decoder (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);
    import riscv_pkg::*;

    // Forced add/sub for address and branch work, funct-driven otherwise.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // Only R-type (op[5]=1) with Instr[30] set is sub; addi never is.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control unit: Moore FSM plus ALU decoder and ImmSrc decode.
// Optional macro CTRL_MEM_WAIT_EN adds a MemReady input that stalls FETCH,
// MEMREAD and MEMWRITE until the memory acknowledges.
module riscv_mc_controller (
    input  logic       clk,
    input  logic       reset,
`ifdef CTRL_MEM_WAIT_EN
    input  logic       MemReady,
`endif
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       IllegalInstr
);
    import riscv_pkg::*;

    state_t     state_q, state_d;
    logic       mem_ready;
    logic       pc_update, branch;
    logic       ir_write, reg_write, mem_write, illegal;
    logic [1:0] alu_op;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and raw (ungated) control decode.
    always_comb begin
        state_d   = state_q;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                // Latch the instruction and bump PC only once memory delivers.
                ir_write  = mem_ready;
                pc_update = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target PC+imm is computed here and parked in ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMMEXT;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMMEXT;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                // Strobe held for the whole wait so the memory sees a stable request.
                mem_write = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_FUNC;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMMEXT;
                alu_op  = ALUOP_FUNC;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                // 0 + U-immediate passes the upper immediate straight through.
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMMEXT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target from DECODE) while ALU forms OldPC+4 for rd.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are suppressed while reset is asserted; selects stay as decoded.
    always_comb begin
        PCWrite      = ~reset & (pc_update | (branch & (Zero ^ funct3[0])));
        IRWrite      = ~reset & ir_write;
        RegWrite     = ~reset & reg_write;
        MemWrite     = ~reset & mem_write;
        IllegalInstr = ~reset & illegal;
        ImmSrc       = imm_src_of(op);
    end

    riscv_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench for riscv_mc_controller: stimulus pushes the expected
// per-cycle control vector, a negedge monitor pops and compares.
module tb_riscv_mc_controller;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    riscv_mc_controller dut (
        .clk          (clk),
        .reset        (reset),
`ifdef CTRL_MEM_WAIT_EN
        .MemReady     (mem_ready),
`endif
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .ImmSrc       (ImmSrc),
        .IllegalInstr (IllegalInstr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [17:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 1'b0;

    // Vector layout: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc Illegal
    function automatic logic [17:0] ev(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [2:0] imm,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
    endfunction

    function automatic logic [17:0] v_rst(input logic [2:0] imm);
        return ev(L, L, L, L, L, 2'b10, 2'b00, 2'b10, 3'b000, imm, L);
    endfunction
    function automatic logic [17:0] v_fetch(input logic [2:0] imm);
        return ev(H, L, L, H, L, 2'b10, 2'b00, 2'b10, 3'b000, imm, L);
    endfunction
    function automatic logic [17:0] v_decode(input logic [2:0] imm, input logic ill);
        return ev(L, L, L, L, L, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill);
    endfunction
    function automatic logic [17:0] v_aluwb(input logic [2:0] imm);
        return ev(L, L, L, L, H, 2'b00, 2'b00, 2'b00, 3'b000, imm, L);
    endfunction

    // Push the expectation for the current cycle, then advance one clock.
    task automatic cyc(input string name, input logic [17:0] v);
        exp_t e;
        e.name = name;
        e.vec  = v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    endtask

    task automatic fetch_decode(input string tag, input logic [2:0] imm);
        cyc({tag, "_fetch"}, v_fetch(imm));
        cyc({tag, "_decode"}, v_decode(imm, L));
    endtask

    task automatic rtype(input string tag, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        set_instr(7'b0110011, f3, f7, L);
        fetch_decode(tag, 3'b000);
        cyc({tag, "_execr"}, ev(L, L, L, L, L, 2'b00, 2'b10, 2'b00, alu, 3'b000, L));
        cyc({tag, "_aluwb"}, v_aluwb(3'b000));
    endtask

    task automatic itype(input string tag, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        set_instr(7'b0010011, f3, f7, L);
        fetch_decode(tag, 3'b000);
        cyc({tag, "_execi"}, ev(L, L, L, L, L, 2'b00, 2'b10, 2'b01, alu, 3'b000, L));
        cyc({tag, "_aluwb"}, v_aluwb(3'b000));
    endtask

    task automatic branch(input string tag, input logic [2:0] f3, input logic z, input logic pcw);
        set_instr(7'b1100011, f3, L, z);
        fetch_decode(tag, 3'b010);
        cyc({tag, "_branch"}, ev(pcw, L, L, L, L, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, L));
    endtask

    // Monitor: one comparison per cycle whenever an expectation is pending.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [17:0] got;
            e = exp_q.pop_front();
            got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalInstr};
            n_checks++;
            if (got === e.vec) begin
                n_pass++;
                $display("ok   %-18s vec=%05h", e.name, got);
            end else begin
                $display("FAIL %-18s got=%05h exp=%05h", e.name, got, e.vec);
            end
        end
    end

    initial begin
        // Reset held for two cycles with a load on the instruction bus.
        set_instr(7'b0000011, 3'b010, L, L);
        @(posedge clk);
        #1;
        cyc("rst0", v_rst(3'b000));
        cyc("rst1", v_rst(3'b000));
        reset = 1'b0;

        // lw: 5 cycles
        fetch_decode("lw", 3'b000);
        cyc("lw_memadr", ev(L, L, L, L, L, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, L));
        cyc("lw_memread", ev(L, H, L, L, L, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, L));
        cyc("lw_memwb", ev(L, L, L, L, H, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, L));

        // sub x2,x1,x2 (0x40208133), then or/slt/xor(add) R-types
        rtype("sub", 3'b000, H, 3'b001);
        rtype("or", 3'b110, L, 3'b011);
        rtype("slt", 3'b010, L, 3'b101);
        rtype("xor", 3'b100, L, 3'b000);

        // Branches: beq/bne, taken and not taken
        branch("beq_z1", 3'b000, H, H);
        branch("beq_z0", 3'b000, L, L);
        branch("bne_z1", 3'b001, H, L);
        branch("bne_z0", 3'b001, L, H);

        // sw: 4 cycles, S-immediate
        set_instr(7'b0100011, 3'b010, L, L);
        fetch_decode("sw", 3'b001);
        cyc("sw_memadr", ev(L, L, L, L, L, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, L));
        cyc("sw_memwrite", ev(L, H, H, L, L, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, L));

        // jal: J-immediate, PC updated in JAL state
        set_instr(7'b1101111, 3'b000, L, L);
        fetch_decode("jal", 3'b011);
        cyc("jal_jal", ev(H, L, L, L, L, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, L));
        cyc("jal_aluwb", v_aluwb(3'b011));

        // lui: U-immediate, SrcA = zero
        set_instr(7'b0110111, 3'b000, L, L);
        fetch_decode("lui", 3'b100);
        cyc("lui_lui", ev(L, L, L, L, L, 2'b00, 2'b11, 2'b01, 3'b000, 3'b100, L));
        cyc("lui_aluwb", v_aluwb(3'b100));

        // I-types: addi with Instr[30]=1 must still add; andi; slti
        itype("addi", 3'b000, H, 3'b000);
        itype("andi", 3'b111, L, 3'b010);
        itype("slti", 3'b010, L, 3'b101);

        // Illegal opcode: one-cycle pulse in DECODE, then straight back to FETCH
        set_instr(7'b1111111, 3'b000, L, L);
        cyc("ill_fetch", v_fetch(3'b000));
        cyc("ill_decode", v_decode(3'b000, H));
        cyc("ill_refetch", v_fetch(3'b000));
        cyc("ill_decode2", v_decode(3'b000, H));

        // Reset during EXECR: next cycle is FETCH with no RegWrite
        set_instr(7'b0110011, 3'b000, L, L);
        fetch_decode("abort", 3'b000);
        cyc("abort_execr", ev(L, L, L, L, L, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, L));
        reset = 1'b1;
        cyc("abort_rst", v_rst(3'b000));
        reset = 1'b0;
        cyc("abort_fetch", v_fetch(3'b000));
        cyc("abort_decode", v_decode(3'b000, L));

`ifdef CTRL_MEM_WAIT_EN
        // Memory wait: drain into a clean FETCH first
        cyc("mw_execr", ev(L, L, L, L, L, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, L));
        cyc("mw_aluwb", v_aluwb(3'b000));
        set_instr(7'b0100011, 3'b010, L, L);
        mem_ready = 1'b0;
        cyc("mw_fetch_hold", v_rst(3'b001));
        mem_ready = 1'b1;
        fetch_decode("mw_sw", 3'b001);
        cyc("mw_sw_memadr", ev(L, L, L, L, L, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, L));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("mw_sw_hold", ev(L, H, H, L, L, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, L));
        mem_ready = 1'b1;
        cyc("mw_sw_memwrite", ev(L, H, H, L, L, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, L));
        cyc("mw_sw_next", v_fetch(3'b001));
`endif

        stim_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=stim_done=%0d exp=1", stim_done);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
- Control unit for the multicycle RV32I core.
- Sequences the shared datapath (one ALU, one memory port, immediate extender) through per-instruction state sequences.
- Inputs: opcode/funct fields from the instruction register and the ALU Zero flag.
- Outputs: every datapath enable and mux select, including the 3-bit ImmSrc that drives the immediate extender.

Parameters:
- none (encodings fixed in the shared package)

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU result == 0
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register / OldPC enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- IllegalInstr  out  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- Moore FSM: state register plus a combinational output decode. PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])), so beq and bne are both supported.
- Reset:
  - Asynchronous; state goes to FETCH.
  - While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and IllegalInstr are forced to 0. Mux selects show FETCH values.
  - Reset asserted mid-instruction aborts the instruction with no further writes.
- States, transitions and non-default outputs. Defaults are all enables 0 and selects 00.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target precomputed). Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - any other op -> FETCH, with IllegalInstr=1 and no architectural write
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD if op[5]=0, otherwise MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=func. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=func. Next: ALUWB.
  - LUI: ALUSrcA=11, ALUSrcB=01, add. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- Instruction latencies: load 5 cycles; store, R, I, LUI and JAL 4; branch 3; illegal 2.
- ALU decode (ALUOp=func):
  - funct3=000: sub if op[5] & funct7b5, otherwise add
  - 010: slt
  - 110: or
  - 111: and
  - any other funct3: add
- ImmSrc: combinational from op, independent of state.
  - 0100011 -> S
  - 1100011 -> B
  - 1101111 -> J
  - 0110111 -> U
  - all other op -> I

Optional Feature:
- Macro CTRL_MEM_WAIT_EN.
- When defined:
  - Adds input MemReady (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold while MemReady=0.
  - During a FETCH hold, IRWrite and PCUpdate are 0. They assert only in the cycle MemReady=1.
  - MemWrite stays asserted throughout a MEMWRITE hold.
  - An advance occurs only on MemReady=1.
- When undefined: no MemReady port; behaviour is identical to MemReady tied to 1.

Decomposition:
- Package riscv_pkg holds:
  - state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_LUI)
  - ALUControl encodings
  - ImmSrc encodings
  - ALUOp encodings
- One sub-module, riscv_alu_decoder: inputs ALUOp, funct3, op[5], funct7b5; output ALUControl.

Test Plan:
- Reset held high for 2 cycles, then released, with op=0000011 -> during reset all enables 0; after release: FETCH (IRWrite=1, PCWrite=1), DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (RegWrite=1, ResultSrc=01), FETCH.
- sub, Instr=0x40208133 -> EXECR with ALUControl=001, then ALUWB with RegWrite=1; 4 cycles total.
- beq, op=1100011 funct3=000: Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> PCWrite=0. bne (funct3=001): inverse.
- Each opcode in turn (sw, beq, jal, lui, addi) -> ImmSrc 001, 010, 011, 100, 000; lui reaches ALUWB with ALUSrcA=11.
- op=1111111 -> IllegalInstr=1 for exactly one cycle in DECODE, next state FETCH, no RegWrite or MemWrite. Separately, reset pulsed in EXECR -> next cycle FETCH with no RegWrite.
- CTRL_MEM_WAIT_EN defined, sw with MemReady=0 for 3 cycles -> MemWrite held for 4 cycles; FETCH after MemReady=1; IRWrite=0 until MemReady=1.
